// File: rtl/clock_set_fsm.sv
// clock_set_fsm: turns debounced button strobes into time-set and alarm-set
// edits, holds the edit registers and the committed alarm, and issues a
// one-cycle load strobe to the timekeeper when a new time is committed.
module clock_set_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 120000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       setEvent,
  input  logic       alarmEvent,
  input  logic       incEvent,
  input  logic       decEvent,
  input  logic [4:0] curHour,
  input  logic [5:0] curMin,
  output logic [2:0] mode,
  output logic [4:0] editHour,
  output logic [5:0] editMin,
  output logic       loadTime,
  output logic [4:0] setHour,
  output logic [5:0] setMin,
  output logic [4:0] alarmHour,
  output logic [5:0] alarmMin,
  output logic       alarmEn
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    ALM_HOUR = 3'd3,
    ALM_MIN  = 3'd4
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mode_e            state_q;
  logic [4:0]       edit_hour_q;
  logic [5:0]       edit_min_q;
  logic             load_time_q;
  logic [4:0]       set_hour_q;
  logic [5:0]       set_min_q;
  logic [4:0]       alarm_hour_q;
  logic [5:0]       alarm_min_q;
  logic             alarm_en_q;
  logic [CNT_W-1:0] cnt_q;

  // Prioritised, mutually exclusive event view of the four strobes.
  logic ev_set, ev_alarm, ev_inc, ev_dec, ev_any;

  // Wrapping modulo-24 / modulo-60 step helpers.
  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hour_dec(input logic [4:0] h);
    return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] m);
    return (m == 6'd0 || m > 6'd59) ? 6'd59 : m - 6'd1;
  endfunction

  // Priority decode: set > alarm > inc > dec; lower ones are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    ev_set   = 1'b0;
    ev_alarm = 1'b0;
    ev_inc   = 1'b0;
    ev_dec   = 1'b0;
    if (setEvent)        ev_set   = 1'b1;
    else if (alarmEvent) ev_alarm = 1'b1;
    else if (incEvent)   ev_inc   = 1'b1;
    else if (decEvent)   ev_dec   = 1'b1;
    ev_any = ev_set | ev_alarm | ev_inc | ev_dec;
  end

  // Edit state machine with all outputs registered.
  always_ff @(posedge mclk or posedge rst) begin
    // NOTE: the reset branch clears every register, including the committed
    // alarm, so a reset mid-edit leaves nothing half-applied.
    if (rst) begin
      state_q      <= IDLE;
      edit_hour_q  <= '0;
      edit_min_q   <= '0;
      load_time_q  <= 1'b0;
      set_hour_q   <= '0;
      set_min_q    <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_en_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      load_time_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ev_set) begin
            state_q     <= SET_HOUR;
            edit_hour_q <= (curHour > 5'd23) ? 5'd0 : curHour;
            edit_min_q  <= (curMin > 6'd59) ? 6'd0 : curMin;
          end else if (ev_alarm) begin
            state_q     <= ALM_HOUR;
            edit_hour_q <= alarm_hour_q;
            edit_min_q  <= alarm_min_q;
          end else if (ev_inc) begin
            alarm_en_q <= ~alarm_en_q;
          end
        end

        SET_HOUR, SET_MIN, ALM_HOUR, ALM_MIN: begin
          if (ev_any) cnt_q <= '0;

          if (ev_set) begin
            if (state_q == SET_HOUR) begin
              state_q <= SET_MIN;
            end else if (state_q == SET_MIN) begin
              state_q     <= IDLE;
              load_time_q <= 1'b1;
              set_hour_q  <= edit_hour_q;
              set_min_q   <= edit_min_q;
            end else begin
              state_q <= IDLE;      // abort alarm edit
            end
          end else if (ev_alarm) begin
            if (state_q == ALM_HOUR) begin
              state_q <= ALM_MIN;
            end else if (state_q == ALM_MIN) begin
              state_q      <= IDLE;
              alarm_hour_q <= edit_hour_q;
              alarm_min_q  <= edit_min_q;
              alarm_en_q   <= 1'b1;
            end else begin
              state_q <= IDLE;      // abort time edit
            end
          end else if (ev_inc) begin
            if (state_q == SET_HOUR || state_q == ALM_HOUR)
              edit_hour_q <= hour_inc(edit_hour_q);
            else
              edit_min_q <= min_inc(edit_min_q);
          end else if (ev_dec) begin
            if (state_q == SET_HOUR || state_q == ALM_HOUR)
              edit_hour_q <= hour_dec(edit_hour_q);
            else
              edit_min_q <= min_dec(edit_min_q);
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;        // inactivity abort, nothing committed
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign mode      = state_q;
  assign editHour  = edit_hour_q;
  assign editMin   = edit_min_q;
  assign loadTime  = load_time_q;
  assign setHour   = set_hour_q;
  assign setMin    = set_min_q;
  assign alarmHour = alarm_hour_q;
  assign alarmMin  = alarm_min_q;
  assign alarmEn   = alarm_en_q;

endmodule

// File: tb/tb_clock_set_fsm.sv
// Bench for clock_set_fsm: directed scenarios followed by random strobes,
// every cycle compared against an arithmetic model of the edit rules.
module tb_clock_set_fsm;

  localparam int TO = 20;

  logic       mclk = 1'b0;
  logic       rst  = 1'b1;
  logic       setEvent = 1'b0, alarmEvent = 1'b0, incEvent = 1'b0, decEvent = 1'b0;
  logic [4:0] curHour = '0;
  logic [5:0] curMin  = '0;
  logic [2:0] mode;
  logic [4:0] editHour, setHour, alarmHour;
  logic [5:0] editMin, setMin, alarmMin;
  logic       loadTime, alarmEn;

  int checks   = 0;
  int failures = 0;

  clock_set_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .mclk(mclk), .rst(rst),
    .setEvent(setEvent), .alarmEvent(alarmEvent),
    .incEvent(incEvent), .decEvent(decEvent),
    .curHour(curHour), .curMin(curMin),
    .mode(mode), .editHour(editHour), .editMin(editMin),
    .loadTime(loadTime), .setHour(setHour), .setMin(setMin),
    .alarmHour(alarmHour), .alarmMin(alarmMin), .alarmEn(alarmEn)
  );

  always #5 mclk = ~mclk;

  // Reference model: mode number, edit values as plain integers.
  int m_mode, m_eh, m_em, m_load, m_sh, m_sm, m_ah, m_am, m_en, m_idle;

  task automatic model_reset();
    m_mode = 0; m_eh = 0; m_em = 0; m_load = 0; m_sh = 0; m_sm = 0;
    m_ah = 0; m_am = 0; m_en = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit i, input bit d);
    bit hour_field;
    m_load = 0;
    hour_field = (m_mode == 1 || m_mode == 3);
    if (m_mode == 0) begin
      m_idle = 0;
      if (s) begin
        m_mode = 1;
        m_eh = (int'(curHour) < 24) ? int'(curHour) : 0;
        m_em = (int'(curMin) < 60) ? int'(curMin) : 0;
      end else if (a) begin
        m_mode = 3; m_eh = m_ah; m_em = m_am;
      end else if (i) begin
        m_en = 1 - m_en;
      end
    end else begin
      if (s || a || i || d) m_idle = 0;
      if (s) begin
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) begin
          m_mode = 0; m_load = 1; m_sh = m_eh; m_sm = m_em;
        end else m_mode = 0;
      end else if (a) begin
        if (m_mode == 3) m_mode = 4;
        else if (m_mode == 4) begin
          m_mode = 0; m_ah = m_eh; m_am = m_em; m_en = 1;
        end else m_mode = 0;
      end else if (i) begin
        if (hour_field) m_eh = (m_eh + 1) % 24;
        else            m_em = (m_em + 1) % 60;
      end else if (d) begin
        if (hour_field) m_eh = (m_eh + 23) % 24;
        else            m_em = (m_em + 59) % 60;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_mode = 0; m_idle = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mode"},      32'(mode),      32'(m_mode));
    check({tag, ".editHour"},  32'(editHour),  32'(m_eh));
    check({tag, ".editMin"},   32'(editMin),   32'(m_em));
    check({tag, ".loadTime"},  32'(loadTime),  32'(m_load));
    check({tag, ".setHour"},   32'(setHour),   32'(m_sh));
    check({tag, ".setMin"},    32'(setMin),    32'(m_sm));
    check({tag, ".alarmHour"}, 32'(alarmHour), 32'(m_ah));
    check({tag, ".alarmMin"},  32'(alarmMin),  32'(m_am));
    check({tag, ".alarmEn"},   32'(alarmEn),   32'(m_en));
  endtask

  // One clock: drive strobes at the falling edge, check 1 ns after rising.
  task automatic cyc(input string tag, input bit s, input bit a, input bit i, input bit d);
    @(negedge mclk);
    setEvent = s; alarmEvent = a; incEvent = i; decEvent = d;
    @(posedge mclk);
    model_step(s, a, i, d);
    #1;
    check_all(tag);
    setEvent = 0; alarmEvent = 0; incEvent = 0; decEvent = 0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge mclk);
    rst = 1'b0;
  endtask

  // Hard bound on total run time.
  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge mclk);
    rst = 1'b0;

    // Time set: 10:30 -> 13:28 committed.
    curHour = 5'd10; curMin = 6'd30;
    cyc("ts_enter", 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("ts_inc", 0, 0, 1, 0);
    cyc("ts_to_min", 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc("ts_dec", 0, 0, 0, 1);
    cyc("ts_commit", 1, 0, 0, 0);
    check("ts_load_pulse", 32'(loadTime), 32'd1);
    check("ts_setHour",    32'(setHour),  32'd13);
    check("ts_setMin",     32'(setMin),   32'd28);
    cyc("ts_after", 0, 0, 0, 0);
    check("ts_load_single", 32'(loadTime), 32'd0);
    check("ts_mode_idle",   32'(mode),     32'd0);

    // Wraps: hour 23 <-> 0, minute 0 -> 59, then alarm aborts SET_MIN.
    curHour = 5'd23; curMin = 6'd0;
    cyc("wr_enter", 1, 0, 0, 0);
    cyc("wr_hinc", 0, 0, 1, 0);
    check("wr_hour0", 32'(editHour), 32'd0);
    cyc("wr_hdec", 0, 0, 0, 1);
    check("wr_hour23", 32'(editHour), 32'd23);
    cyc("wr_to_min", 1, 0, 0, 0);
    cyc("wr_mdec", 0, 0, 0, 1);
    check("wr_min59", 32'(editMin), 32'd59);
    cyc("wr_abort", 0, 1, 0, 0);
    check("wr_abort_load", 32'(loadTime), 32'd0);

    // Alarm set 7:59 and enable, then toggle off in IDLE.
    cyc("al_enter", 0, 1, 0, 0);
    for (int k = 0; k < 7; k++) cyc("al_inc", 0, 0, 1, 0);
    cyc("al_to_min", 0, 1, 0, 0);
    cyc("al_dec", 0, 0, 0, 1);
    cyc("al_commit", 0, 1, 0, 0);
    check("al_hour", 32'(alarmHour), 32'd7);
    check("al_min",  32'(alarmMin),  32'd59);
    check("al_en",   32'(alarmEn),   32'd1);
    cyc("al_toggle", 0, 0, 1, 0);
    check("al_en_off", 32'(alarmEn), 32'd0);

    // Timeout after TO idle cycles in an edit state.
    curHour = 5'd4; curMin = 6'd5;
    cyc("to_enter", 1, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) cyc("to_wait", 0, 0, 0, 0);
    check("to_still_edit", 32'(mode), 32'd1);
    cyc("to_expire", 0, 0, 0, 0);
    check("to_idle", 32'(mode), 32'd0);

    // Priority: set beats inc from IDLE; set beats all in SET_HOUR.
    curHour = 5'd9; curMin = 6'd1;
    cyc("pr_set_inc", 1, 0, 1, 0);
    check("pr_hour_unincremented", 32'(editHour), 32'd9);
    cyc("pr_all", 1, 1, 1, 1);
    check("pr_to_setmin", 32'(mode), 32'd2);
    cyc("pr_abort", 0, 1, 1, 0);

    // Out-of-range current time loads as zero.
    curHour = 5'd30; curMin = 6'd63;
    cyc("oor_enter", 1, 0, 0, 0);
    cyc("oor_abort", 0, 1, 0, 0);

    // Reset in the middle of a minute edit after a committed alarm.
    cyc("rm_alarm", 0, 1, 0, 0);
    cyc("rm_alarm_min", 0, 1, 0, 0);
    cyc("rm_alarm_commit", 0, 1, 0, 0);
    curHour = 5'd2; curMin = 6'd10;
    cyc("rm_enter", 1, 0, 0, 0);
    cyc("rm_to_min", 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc("rm_inc", 0, 0, 1, 0);
    async_reset("rm_reset");
    cyc("rm_after", 0, 0, 0, 0);

    // Random strobes with random (partly out-of-range) current time.
    for (int n = 0; n < 1500; n++) begin
      int pct;
      pct = (n < 900) ? 15 : 3;
      curHour = 5'($urandom_range(0, 31));
      curMin  = 6'($urandom_range(0, 63));
      cyc("rnd",
          $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct,
          $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
      if (n == 1200) async_reset("rnd_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_fsm.md
Name: clock_set_fsm

Overview:
- Consumer side of the button path: takes the one-cycle debounced press strobes from button_controller and turns them into time-set and alarm-set edits.
- Holds the edit registers shown by the LCD path, the committed alarm time and the alarm enable.
- Issues a one-cycle load strobe to the timekeeper when a new time is committed.
- Sits between button_controller (upstream) and the timekeeper/LCD formatting logic (downstream).

Parameters:
TIMEOUT_CYCLES, 120000000, idle cycles in any edit state before auto-abort (10 s at 12 MHz); benches override with a small value.
CNT_W, 32, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
mclk  input  1  system clock (all logic on rising edge)
rst  input  1  reset, asynchronous and active-high
setEvent  input  1  one-cycle strobe: Set button pressed
alarmEvent  input  1  one-cycle strobe: Alarm button pressed
incEvent  input  1  one-cycle strobe: Button0 pressed (increment)
decEvent  input  1  one-cycle strobe: Button1 pressed (decrement)
curHour  input  5  current hour from timekeeper, 0..23
curMin  input  6  current minute from timekeeper, 0..59
mode  output  3  0 IDLE, 1 SET_HOUR, 2 SET_MIN, 3 ALM_HOUR, 4 ALM_MIN
editHour  output  5  hour value under edit
editMin  output  6  minute value under edit
loadTime  output  1  one-cycle commit strobe to timekeeper
setHour  output  5  hour to load; valid while loadTime=1
setMin  output  6  minute to load; valid while loadTime=1
alarmHour  output  5  committed alarm hour
alarmMin  output  6  committed alarm minute
alarmEn  output  1  alarm enable

Behaviour:
- Reset (asynchronous, any time): mode=IDLE, editHour=0, editMin=0, loadTime=0, setHour=0, setMin=0, alarmHour=0, alarmMin=0, alarmEn=0, timeout counter=0.
- Reset in the middle of an edit discards the edit and produces no loadTime.
- Events are sampled on the rising mclk edge. The resulting state and register changes are visible in the next cycle, so latency is 1 cycle.
- Priority when events coincide: setEvent > alarmEvent > incEvent > decEvent. Only the highest-priority event is acted on; the others in that cycle are dropped.
- IDLE:
  - setEvent: go to SET_HOUR; editHour←curHour, editMin←curMin. Either value out of range (hour >23, minute >59) loads as 0.
  - alarmEvent: go to ALM_HOUR; editHour←alarmHour, editMin←alarmMin.
  - incEvent: toggle alarmEn.
  - decEvent: ignored.
- SET_HOUR:
  - incEvent: editHour+1, 23 wraps to 0.
  - decEvent: editHour-1, 0 wraps to 23.
  - setEvent: go to SET_MIN.
  - alarmEvent: abort to IDLE, no commit.
- SET_MIN:
  - incEvent/decEvent: editMin ±1, wrapping 59↔0.
  - setEvent: go to IDLE and commit. loadTime=1 for exactly one cycle (the cycle after the event), with setHour=editHour and setMin=editMin. setHour/setMin hold those values afterwards.
  - alarmEvent: abort to IDLE, no commit.
- ALM_HOUR / ALM_MIN: same increment, decrement and wrap rules as SET_HOUR / SET_MIN.
  - alarmEvent advances ALM_HOUR→ALM_MIN.
  - alarmEvent in ALM_MIN: go to IDLE, alarmHour←editHour, alarmMin←editMin, alarmEn←1. No loadTime.
  - setEvent in either alarm state: abort to IDLE, alarm registers unchanged.
- Timeout:
  - The counter clears on any accepted event and on entry to an edit state, and increments every cycle while mode≠IDLE.
  - When it reaches TIMEOUT_CYCLES: go to IDLE with no commit.
  - The counter is held at 0 in IDLE.
- editHour/editMin keep their last values in IDLE. They are only reloaded on entry to an edit state.
- loadTime never asserts on two consecutive cycles.

Test Plan:
- Reset: assert rst mid-run asynchronously → all outputs 0 in the same delta, mode=IDLE, no loadTime.
- Time set: curHour=10, curMin=30; setEvent, 3×incEvent, setEvent, 2×decEvent, setEvent → loadTime single pulse with setHour=13, setMin=28, then mode=0.
- Wrap: in SET_HOUR from 23, incEvent → editHour=0, decEvent → 23. In SET_MIN from 0, decEvent → editMin=59.
- Alarm set and enable: alarmEvent, 7×incEvent, alarmEvent, decEvent, alarmEvent → alarmHour=7, alarmMin=59, alarmEn=1, loadTime never asserted. Then incEvent in IDLE → alarmEn=0.
- Abort, timeout and priority:
  - TIMEOUT_CYCLES=20: setEvent, then idle 20 cycles → mode=IDLE, no loadTime.
  - setEvent and incEvent in the same cycle from IDLE → mode=SET_HOUR, editHour=curHour unincremented.
  - alarmEvent during SET_MIN → IDLE, no loadTime.
- Reset mid-edit: in SET_MIN after 5×incEvent, pulse rst → mode=IDLE, editMin=0, no loadTime; alarm registers return to 0.
